// File: rtl/pipe_reg_chain.sv
// Multi-stage valid/ready register pipeline with bubble collapsing,
// synchronous flush and an occupancy count (clk, reset, flush, in_*, out_*, count).
module pipe_reg_chain #(
  parameter int unsigned          DATA_W    = 8,
  parameter int unsigned          DEPTH     = 3,
  parameter logic [DATA_W-1:0]    RESET_VAL = '0,
  localparam int unsigned         CW        = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CW-1:0]     count
);

  logic [DEPTH-1:0]  r_valid;
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [CW-1:0]     r_count;

  logic [DEPTH-1:0]  w_move;
  logic [DEPTH-1:0]  w_accept;
  logic [DEPTH-1:0]  w_load;
  logic [DEPTH-1:0]  w_valid_nxt;
  logic [DATA_W-1:0] w_din [DEPTH];
  logic [CW-1:0]     w_cnt_nxt;
  logic              w_in_ready;
  logic              w_acc;

  // Ready ripples from the output stage back toward stage 0, so an
  // empty stage always accepts even while the output is stalled.
  always_comb begin
    w_move   = '0;
    w_accept = '0;
    w_acc    = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_move[i]   = r_valid[i] && w_acc;
      w_accept[i] = !r_valid[i] || w_move[i];
      w_acc       = w_accept[i];
    end
  end

  assign w_in_ready = w_accept[0] && !flush;

  always_comb begin
    w_load    = '0;
    w_load[0] = in_valid && w_in_ready;
    w_din[0]  = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      w_load[i] = w_move[i-1];
      w_din[i]  = r_data[i-1];
    end
  end

  always_comb begin
    w_valid_nxt = r_valid;
    w_cnt_nxt   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_load[i])
        w_valid_nxt[i] = 1'b1;
      else if (w_move[i])
        w_valid_nxt[i] = 1'b0;
      w_cnt_nxt = w_cnt_nxt + CW'(w_valid_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++)
        r_data[i] <= RESET_VAL;
    end else if (flush) begin
      // Data registers keep stale contents; only occupancy is cleared.
      r_valid <= '0;
      r_count <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      r_count <= w_cnt_nxt;
      for (int i = 0; i < DEPTH; i++)
        if (w_load[i])
          r_data[i] <= w_din[i];
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_valid[DEPTH-1] && !flush;
  assign out_data  = r_data[DEPTH-1];
  assign count     = r_count;

endmodule

// File: doc/pipe_reg_chain.md
Name: pipe_reg_chain

Overview:
- Parametrised multi-stage register pipeline with a valid/ready handshake on both sides.
- Generalises the single D flip-flop with synchronous active-low clear to DATA_W-wide data and DEPTH stages.
- Adds per-stage valid tracking, backpressure with bubble collapsing, synchronous flush and an occupancy count.
- Used in control paths to retime buses between blocks that may stall.

Parameters:
- DATA_W, 8, payload width in bits (>=1).
- DEPTH, 3, number of register stages (>=1).
- RESET_VAL, 0, value loaded into every stage data register on reset (DATA_W bits).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- flush  input  1  synchronous pipeline clear, active-high.
- in_valid  input  1  upstream presents in_data.
- in_ready  output  1  pipeline accepts in_data this cycle.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  stage DEPTH-1 holds valid data.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  DATA_W  payload of stage DEPTH-1.
- count  output  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- Interface: reset is synchronous, active-low; clock is clk. All state updates on posedge clk only.
- Reset (reset==0 at a posedge):
  - All stage valid bits become 0; all stage data registers become RESET_VAL.
  - Therefore out_valid=0, out_data=RESET_VAL, count=0.
  - Reset has priority over flush and over any handshake in the same cycle.
- Per-stage state: valid[i], data[i], for i=0..DEPTH-1. Stage 0 is the input stage; stage DEPTH-1 is the output stage.
- move[i] (combinational):
  - For i=DEPTH-1: valid[i] && out_ready.
  - Otherwise: valid[i] && accept[i+1].
- accept[i] = !valid[i] || move[i].
- Outputs:
  - in_ready = accept[0] && !flush.
  - out_valid = valid[DEPTH-1] && !flush.
  - out_data = data[DEPTH-1].
- Loading a stage:
  - load[0] = in_valid && in_ready.
  - load[i] = move[i-1] for i>0.
  - On load, data[i] takes the upstream data and valid[i] becomes 1.
  - Otherwise, if move[i], valid[i] becomes 0 and data[i] holds.
  - Otherwise the stage holds both valid and data.
- Data registers of empty stages keep their stale value; no requirement on their contents beyond reset.
- Bubble collapsing: a stalled output does not stall upstream empty stages. Words advance into holes, so the pipeline fills to DEPTH words under sustained stall.
- Latency and throughput:
  - A word accepted at edge N is visible on out_valid after edge N+DEPTH-1 when unobstructed (DEPTH register delays).
  - Throughput is 1 word/cycle with out_ready held at 1.
- Full: count==DEPTH and out_ready==0 gives in_ready=0. With count==DEPTH and out_ready==1, in_ready=1 in the same cycle (combinational pass-through of ready).
- Empty: count==0 gives out_valid=0 and in_ready=1 (absent flush).
- Flush (flush==1, reset==1):
  - in_ready=0 and out_valid=0 in that cycle, so no handshake completes.
  - All valid bits become 0 at the edge; data registers hold.
  - count==0 from the next cycle.
- count: registered popcount of valid bits after each edge; never exceeds DEPTH.
- Handshake rules:
  - Upstream must hold in_data stable while in_valid && !in_ready. The block does not check this.
  - out_data and out_valid are stable while out_valid && !out_ready (absent flush or reset).
- Reset mid-operation discards all in-flight words; no partial word ever reaches the output.
- DEPTH=1 degenerates to a single registered slot with the same rules.

Test Plan:
- Reset: DATA_W=8, DEPTH=3, RESET_VAL=8'hA5, reset=0 for 2 cycles with in_valid=1, in_data=8'h11 -> out_valid=0, out_data=8'hA5, count=0, no word accepted.
- Latency and streaming: out_ready=1, words 8'h01..8'h08 on consecutive cycles -> 8'h01 on out_valid 3 edges after acceptance, then one word per cycle in order, in_ready always 1, count steady at 3.
- Backpressure and bubble collapse: out_ready=0, send 8'h10, idle 1 cycle, then send 8'h20 and 8'h30 -> count rises to 3 with no gaps, in_ready=0 afterwards. Then out_ready=1 -> out_data 8'h10, 8'h20, 8'h30 on consecutive cycles, and in_ready=1 in the first release cycle.
- Full pass-through: pipeline full (count=3), out_ready=1 and in_valid=1 with 8'h44 in the same cycle -> one word leaves, 8'h44 is accepted, count stays 3.
- Flush: count=2, assert flush for 1 cycle with in_valid=1 and out_ready=1 -> in_ready=0 and out_valid=0 during flush, count=0 next cycle, the flushed words never appear, the next accepted word emerges after 3 edges.
- Reset mid-stream: reset=0 for one cycle while count=3 and out_valid=1 -> next cycle out_valid=0, count=0, out_data=RESET_VAL; streaming resumes normally afterwards.
